// File: rtl/hdmi_fb_scanout.sv
// hdmi_fb_scanout
//   Raster timing generator and framebuffer scanner feeding the HDMI TMDS
//   encoders. It produces 640x480@60 timing on pixclk and reads a
//   double-buffered 320x240 RGB555 framebuffer from synchronous-read BRAM.
//   Each framebuffer pixel covers a 2x2 block of screen pixels. pix_data,
//   de, hsync and vsync leave aligned, 3 cycles after the raster counter
//   position they belong to.
//
// Ports
//   pixclk      pixel clock
//   reset       asynchronous, active-high
//   bank_sel    bank requested by the capture side, sampled at frame start
//   fb_rd_en    BRAM read enable (asserted over the active region)
//   fb_addr     {bank, pixel index} to BRAM
//   fb_rdata    BRAM read data, valid one cycle after fb_addr/fb_rd_en
//   pix_data    RGB555 pixel, bit 15 forced to 0, zero during blanking
//   de          active video
//   hsync       horizontal sync, asserted level SYNC_POL
//   vsync       vertical sync, asserted level SYNC_POL
//   frame_start one-cycle pulse when the counters pass (0,0)
//   cur_bank    bank being scanned in the current frame
module hdmi_fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int ADDR_W   = 17,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              bank_sel,
  output logic              fb_rd_en,
  output logic [ADDR_W:0]   fb_addr,
  input  logic [15:0]       fb_rdata,
  output logic [15:0]       pix_data,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              cur_bank
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CX_W    = $clog2(H_TOTAL);
  localparam int CY_W    = $clog2(V_TOTAL);

  localparam logic [CX_W-1:0] CX_LAST    = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0] CX_ACT_END = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0] CX_HS_BEG  = CX_W'(H_ACTIVE + H_FRONT);
  localparam logic [CX_W-1:0] CX_HS_END  = CX_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CY_W-1:0] CY_LAST    = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0] CY_ACT_END = CY_W'(V_ACTIVE);
  localparam logic [CY_W-1:0] CY_VS_BEG  = CY_W'(V_ACTIVE + V_FRONT);
  localparam logic [CY_W-1:0] CY_VS_END  = CY_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  // The 2x upscale and the address width only work for this geometry.
  if (FB_W * 2 != H_ACTIVE || FB_H * 2 != V_ACTIVE ||
      (64'd1 << ADDR_W) < 64'(FB_W * FB_H)) begin : g_geometry_check
    $error("hdmi_fb_scanout: framebuffer geometry does not match raster");
  end

  logic [CX_W-1:0]   cx_p0;
  logic [CY_W-1:0]   cy_p0;
  logic [ADDR_W-1:0] col_p0;
  logic [ADDR_W-1:0] line_base_p0;
  logic              active_p0, hs_p0, vs_p0, origin_p0, bank_next;
  logic [ADDR_W-1:0] pix_index_p0;
  logic              de_p1, hs_p1, vs_p1;
  logic              de_p2, hs_p2, vs_p2;
  logic              unused_rdata_msb;

  assign unused_rdata_msb = fb_rdata[15];

  assign active_p0    = (cx_p0 < CX_ACT_END) && (cy_p0 < CY_ACT_END);
  assign hs_p0        = (cx_p0 >= CX_HS_BEG) && (cx_p0 < CX_HS_END);
  assign vs_p0        = (cy_p0 >= CY_VS_BEG) && (cy_p0 < CY_VS_END);
  assign origin_p0    = (cx_p0 == '0) && (cy_p0 == '0);
  // Pixel (0,0) must already address the bank latched for this frame.
  assign bank_next    = origin_p0 ? bank_sel : cur_bank;
  assign pix_index_p0 = line_base_p0 + col_p0;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      cx_p0        <= '0;
      cy_p0        <= '0;
      col_p0       <= '0;
      line_base_p0 <= '0;
      fb_rd_en     <= 1'b0;
      fb_addr      <= '0;
      frame_start  <= 1'b0;
      cur_bank     <= 1'b0;
      de_p1        <= 1'b0;
      hs_p1        <= 1'b0;
      vs_p1        <= 1'b0;
      de_p2        <= 1'b0;
      hs_p2        <= 1'b0;
      vs_p2        <= 1'b0;
      pix_data     <= '0;
      de           <= 1'b0;
      hsync        <= SYNC_OFF;
      vsync        <= SYNC_OFF;
    end else begin
      // ---- stage 0: raster counters and incremental address ----
      if (cx_p0 == CX_LAST) begin
        cx_p0  <= '0;
        col_p0 <= '0;
        if (cy_p0 == CY_LAST) begin
          cy_p0        <= '0;
          line_base_p0 <= '0;
        end else begin
          cy_p0 <= cy_p0 + 1'b1;
          // Two screen lines share one framebuffer line: advance after the odd one.
          if (cy_p0[0] && (cy_p0 < CY_ACT_END))
            line_base_p0 <= line_base_p0 + LINE_STEP;
        end
      end else begin
        cx_p0 <= cx_p0 + 1'b1;
        if (active_p0 && cx_p0[0])
          col_p0 <= col_p0 + 1'b1;
      end

      // ---- stage 1: BRAM request, bank latch, frame pulse ----
      fb_rd_en    <= active_p0;
      frame_start <= origin_p0;
      cur_bank    <= bank_next;
      if (active_p0)
        fb_addr <= {bank_next, pix_index_p0};
      de_p1 <= active_p0;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;

      // ---- stage 2: BRAM read latency ----
      de_p2 <= de_p1;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;

      // ---- stage 3: aligned outputs ----
      pix_data <= de_p2 ? {1'b0, fb_rdata[14:0]} : 16'h0000;
      de       <= de_p2;
      hsync    <= hs_p2 ? SYNC_ON : SYNC_OFF;
      vsync    <= vs_p2 ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule
